safe_mode_switch_ctrl: RTL

//  Sequences a safe-mode change (single / DMR / TMR) of the CEI safety wrapper.
//  On a software request it interrupts all cores and waits until every core

---
 rtl/safe_mode_switch_ctrl.sv | 107 ++++++++++
 1 files changed

// File: rtl/safe_mode_switch_ctrl.sv
// safe_mode_switch_ctrl: sequences single/DMR/TMR mode changes by parking all cores, applying, then releasing
module safe_mode_switch_ctrl #(
  parameter int NCORES     = 3,
  parameter int TIMEOUT_W  = 16,
  parameter int DEF_MASTER = 0
)(
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      switch_req_i,
  input  logic [1:0]                target_mode_i,
  input  logic [$clog2(NCORES)-1:0] target_master_i,
  input  logic [TIMEOUT_W-1:0]      timeout_i,
  input  logic [NCORES-1:0]         core_sleep_i,
  output logic [NCORES-1:0]         core_intr_o,
  output logic                      intc_ack_o,
  output logic [1:0]                mode_o,
  output logic [$clog2(NCORES)-1:0] master_core_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o
);
  localparam int MW = $clog2(NCORES);
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_APPLY, S_RELEASE, S_ABORT} state_t;
  state_t state, state_nxt;
  logic [TIMEOUT_W-1:0] timer, timer_nxt;
  logic [1:0] tgt_mode, tgt_mode_nxt, mode_nxt;
  logic [MW-1:0] tgt_master, tgt_master_nxt, master_nxt;
  logic [NCORES-1:0] intr_nxt;
  logic ack_nxt, done_nxt, err_nxt, reject;
  assign reject = (target_mode_i == 2'b11) || (32'(target_master_i) >= NCORES);
  // State, latched target and every output are registered; reset returns them all at once
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= S_IDLE;
      timer         <= '0;
      tgt_mode      <= 2'b00;
      tgt_master    <= MW'(DEF_MASTER);
      core_intr_o   <= '0;
      intc_ack_o    <= 1'b0;
      mode_o        <= 2'b00;
      master_core_o <= MW'(DEF_MASTER);
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      state         <= state_nxt;
      timer         <= timer_nxt;
      tgt_mode      <= tgt_mode_nxt;
      tgt_master    <= tgt_master_nxt;
      core_intr_o   <= intr_nxt;
      intc_ack_o    <= ack_nxt;
      mode_o        <= mode_nxt;
      master_core_o <= master_nxt;
      busy_o        <= state_nxt != S_IDLE;
      done_o        <= done_nxt;
      err_o         <= err_nxt;
    end
  end
  // Next state plus next value of each registered output; all-sleep beats timeout in WAIT
  always_comb begin
    state_nxt      = state;
    timer_nxt      = timer;
    tgt_mode_nxt   = tgt_mode;
    tgt_master_nxt = tgt_master;
    intr_nxt       = core_intr_o;
    ack_nxt        = 1'b0;
    done_nxt       = 1'b0;
    err_nxt        = err_o;
    mode_nxt       = mode_o;
    master_nxt     = master_core_o;
    case (state)
      S_IDLE: if (switch_req_i) begin
        if (reject) err_nxt = 1'b1;
        else begin
          state_nxt      = S_WAIT;
          tgt_mode_nxt   = target_mode_i;
          tgt_master_nxt = target_master_i;
          err_nxt        = 1'b0;
          intr_nxt       = '1;
          timer_nxt      = '0;
        end
      end
      S_WAIT: begin
        timer_nxt = &timer ? timer : timer + TIMEOUT_W'(1);
        if (&core_sleep_i) state_nxt = S_APPLY;
        else if (timeout_i != '0 && timer == timeout_i - TIMEOUT_W'(1)) begin
          state_nxt = S_ABORT;
          intr_nxt  = '0;
          ack_nxt   = 1'b1;
          err_nxt   = 1'b1;
        end
      end
      S_APPLY: begin
        state_nxt  = S_RELEASE;
        intr_nxt   = '0;
        ack_nxt    = 1'b1;
        done_nxt   = 1'b1;
        mode_nxt   = tgt_mode;
        master_nxt = tgt_master;
      end
      default: begin
        state_nxt = S_IDLE;
        intr_nxt  = '0;
      end
    endcase
  end
endmodule
